lab_ram_writer: RTL and testbench

//   Write-side sequencer for the LAB sample buffer. Accepts the 16-bit digitized

---
 rtl/lab_ram_writer_if.sv | 29 ++
 rtl/lab_ram_writer.sv | 102 ++++++++++
 tb/tb_lab_ram_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lab_ram_writer_if.sv
// Sample-stream / RAM-write-port bundle for the LAB sample buffer writer.
// The writer takes the slave side; the sample source and readout take the master side.
interface lab_ram_writer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
);
  logic              start_i;
  logic [DATA_W-1:0] dat_i;
  logic              dat_valid_i;
  logic              last_i;
  logic              ack_i;
  logic [DATA_W-1:0] ram_dat_o;
  logic [ADDR_W-1:0] ram_waddr_o;
  logic              ram_wr_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W-1:0] nsamples_o;
  logic              overflow_o;

  modport master (
    output start_i, dat_i, dat_valid_i, last_i, ack_i,
    input  ram_dat_o, ram_waddr_o, ram_wr_o, busy_o, done_o, nsamples_o, overflow_o
  );

  modport slave (
    input  start_i, dat_i, dat_valid_i, last_i, ack_i,
    output ram_dat_o, ram_waddr_o, ram_wr_o, busy_o, done_o, nsamples_o, overflow_o
  );
endinterface

// File: rtl/lab_ram_writer.sv
// Write-side sequencer for the LAB sample buffer: turns one event's sample stream
// into contiguous RAM writes from address 0, holding the buffer until readout acks.
module lab_ram_writer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MAX_SAMPLES = 2340
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  lab_ram_writer_if.slave bus
);

  if (MAX_SAMPLES > 3072 || MAX_SAMPLES < 1) begin : g_bad_max
    $error("lab_ram_writer: MAX_SAMPLES must be within 1..3072");
  end

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] count, count_nx;
  logic [DATA_W-1:0] ram_dat, ram_dat_nx;
  logic [ADDR_W-1:0] ram_waddr, ram_waddr_nx;
  logic              ram_wr, ram_wr_nx;
  logic              busy, busy_nx;
  logic              done, done_nx;
  logic [ADDR_W-1:0] nsamples, nsamples_nx;
  logic              overflow, overflow_nx;
  logic              accept;

  assign accept = (state == CAPTURE) && bus.dat_valid_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      count     <= '0;
      ram_dat   <= '0;
      ram_waddr <= '0;
      ram_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nsamples  <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      ram_dat   <= ram_dat_nx;
      ram_waddr <= ram_waddr_nx;
      ram_wr    <= ram_wr_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      nsamples  <= nsamples_nx;
      overflow  <= overflow_nx;
    end
  end

  // last_i takes priority over hitting the cap, so a full-length event ends cleanly.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start_i) state_nx = CAPTURE;
      CAPTURE: if (accept) begin
                 if (bus.last_i)              state_nx = DONE;
                 else if (count == LAST_IDX)  state_nx = DRAIN;
               end
      DRAIN:   if (bus.dat_valid_i && bus.last_i) state_nx = DONE;
      DONE:    if (bus.ack_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    count_nx     = count;
    ram_dat_nx   = ram_dat;
    ram_waddr_nx = ram_waddr;
    ram_wr_nx    = accept;
    overflow_nx  = overflow;
    if (state == IDLE && bus.start_i) begin
      count_nx    = '0;
      overflow_nx = 1'b0;
    end else if (accept) begin
      count_nx     = count + ADDR_W'(1);
      ram_dat_nx   = bus.dat_i;
      ram_waddr_nx = count;
      if (state_nx == DRAIN) overflow_nx = 1'b1;
    end
    busy_nx     = (state_nx == CAPTURE) || (state_nx == DRAIN);
    // One cycle behind the DONE state so done lands after the final write strobe.
    done_nx     = (state == DONE) && !bus.ack_i;
    nsamples_nx = done_nx ? count : '0;
  end

  assign bus.ram_dat_o   = ram_dat;
  assign bus.ram_waddr_o = ram_waddr;
  assign bus.ram_wr_o    = ram_wr;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.nsamples_o  = nsamples;
  assign bus.overflow_o  = overflow;

endmodule

// File: tb/tb_lab_ram_writer.sv
// Directed bench for lab_ram_writer: a reference model queues each expected RAM
// write (due cycle, address, data) and a monitor pops and checks every strobe.
module tb_lab_ram_writer;
  localparam int MAX = 2340;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lab_ram_writer_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  lab_ram_writer #(.DATA_W(16), .ADDR_W(12), .MAX_SAMPLES(MAX)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          due;
    logic [11:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  typedef enum {M_IDLE, M_CAP, M_DRAIN, M_DONE} mstate_t;
  mstate_t m_st = M_IDLE;
  int      m_count = 0;
  logic    m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ram_wr_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_wr", {20'd0, bus.ram_waddr_o}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_cycle", cyc, e.due);
        check("wr_addr", {20'd0, bus.ram_waddr_o}, {20'd0, e.addr});
        check("wr_data", {16'd0, bus.ram_dat_o}, {16'd0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ev();
    bus.start_i = 1'b1;
    if (m_st == M_IDLE) begin
      m_st = M_CAP; m_count = 0; m_ovf = 1'b0;
    end
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic sample(input logic [15:0] d, input logic l);
    bus.dat_i = d; bus.dat_valid_i = 1'b1; bus.last_i = l;
    if (m_st == M_CAP) begin
      sb.push_back('{cyc + 1, 12'(m_count), d});
      m_count++;
      if (l) m_st = M_DONE;
      else if (m_count == MAX) begin m_st = M_DRAIN; m_ovf = 1'b1; end
    end else if (m_st == M_DRAIN && l) begin
      m_st = M_DONE;
    end
    step();
    bus.dat_valid_i = 1'b0; bus.last_i = 1'b0;
  endtask

  task automatic ack_ev();
    bus.ack_i = 1'b1;
    if (m_st == M_DONE) m_st = M_IDLE;
    step();
    bus.ack_i = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done_early"}, bus.done_o, 1'b0);
    step();
    check({tag, "_done"}, bus.done_o, 1'b1);
    check({tag, "_nsamples"}, bus.nsamples_o, m_count);
    check({tag, "_overflow"}, bus.overflow_o, m_ovf);
    check({tag, "_busy"}, bus.busy_o, 1'b0);
    check({tag, "_pending"}, sb.size(), 0);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.dat_i = '0; bus.dat_valid_i = 1'b0;
    bus.last_i = 1'b0; bus.ack_i = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_outputs", {bus.ram_dat_o, bus.ram_waddr_o, bus.ram_wr_o, bus.busy_o,
                          bus.done_o, bus.overflow_o}, 32'd0);
    check("rst_nsamples", bus.nsamples_o, 0);

    // 1: five-sample event
    start_ev();
    check("t1_busy", bus.busy_o, 1'b1);
    for (int i = 0; i < 5; i++) sample(16'h1000 + 16'(i), i == 4);
    expect_done("t1");

    // 6: valid data in DONE and IDLE is ignored
    sample(16'hDEAD, 1'b1);
    check("t6_done_hold", bus.done_o, 1'b1);
    check("t6_ns_hold", bus.nsamples_o, 5);
    ack_ev();
    check("t1_ack_done", bus.done_o, 1'b0);
    check("t1_ack_ns", bus.nsamples_o, 0);
    sample(16'hBEEF, 1'b0);
    sample(16'hBEEF, 1'b1);
    step();
    check("t6_idle_busy", bus.busy_o, 1'b0);

    // 3: alternating valid gaps keep addresses contiguous
    start_ev();
    for (int i = 0; i < 8; i++) begin
      sample(16'h3000 + 16'(i * 17), i == 7);
      if (i != 7) step();
    end
    expect_done("t3");
    ack_ev();

    // 4: start ignored in CAPTURE/DONE, ack wins over start
    start_ev();
    sample(16'h4000, 1'b0);
    sample(16'h4001, 1'b0);
    start_ev();
    sample(16'h4002, 1'b1);
    expect_done("t4a");
    start_ev();
    check("t4_start_in_done", bus.done_o, 1'b1);
    check("t4_ns_in_done", bus.nsamples_o, 3);
    bus.start_i = 1'b1;
    ack_ev();
    bus.start_i = 1'b0;
    check("t4_ack_wins_done", bus.done_o, 1'b0);
    check("t4_ack_wins_busy", bus.busy_o, 1'b0);
    step();
    check("t4_no_restart", bus.busy_o, 1'b0);
    start_ev();
    for (int i = 0; i < 3; i++) sample(16'h4100 + 16'(i), i == 2);
    expect_done("t4b");
    ack_ev();

    // 2: over-length event is capped, tail drained
    start_ev();
    for (int i = 0; i < MAX + 5; i++) begin
      sample(16'(i * 3 + 7), i == MAX + 4);
      if (i == MAX - 1) begin
        check("t2_ovf_drain", bus.overflow_o, 1'b1);
        check("t2_busy_drain", bus.busy_o, 1'b1);
      end
    end
    expect_done("t2");
    ack_ev();

    // 2b: last exactly on the cap is not an overflow
    start_ev();
    check("t2b_ovf_cleared", bus.overflow_o, 1'b0);
    for (int i = 0; i < MAX; i++) sample(16'(i ^ 16'h5A5A), i == MAX - 1);
    expect_done("t2b");
    ack_ev();

    // 5: asynchronous reset mid-capture
    start_ev();
    for (int i = 0; i < 100; i++) sample(16'h5000 + 16'(i), 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_outputs", {bus.ram_dat_o, bus.ram_waddr_o, bus.ram_wr_o, bus.busy_o,
                             bus.done_o, bus.overflow_o}, 32'd0);
    check("t5_rst_nsamples", bus.nsamples_o, 0);
    check("t5_pending", sb.size(), 0);
    m_st = M_IDLE;
    step();
    rst_n = 1'b1;
    step();
    check("t5_no_done", bus.done_o, 1'b0);
    start_ev();
    for (int i = 0; i < 4; i++) sample(16'h5500 + 16'(i), i == 3);
    expect_done("t5");
    ack_ev();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
